mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and access sequencer for the single-port 8-bit × 8192 system memory of the multicycle CPU. It shares the memory between the CPU memory port and a loader/debug port that preloads programs and data. Fixed priority favours the CPU, with a starvation counter that guarantees the loader a slot. Each winner gets one registered access, followed by a one-cycle acknowledge carrying read data.

## Interface
- ADDR_W, 13, memory address width
- DATA_W, 8, memory data width
- STARVE_LIMIT, 4, consecutive contended CPU grants after which the loader wins the next arbitration (≥1)
- Reset: one clock; reset is synchronous and active-low.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous active-low reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req
- cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1; holds until the next CPU read completes
- ld_req, ld_we, ld_addr, ld_wdata, ld_ack, ld_rdata: same directions, widths and rules as the cpu_* ports
- mem_address  out  ADDR_W  memory address
- mem_inData  out  DATA_W  memory write data
- mem_writeEn  out  1  memory write enable
- mem_outData  in  DATA_W  memory combinational read data
- busy  out  1  1 when the FSM is not in IDLE

## Operation
- FSM states: IDLE, ACCESS, ACK.
- IDLE: if any req=1, arbitrate and go to ACCESS. Latch winner id, we, addr and wdata into mem_address, mem_inData and the internal we_q. With no request, stay in IDLE.
- Arbitration:
  - Only CPU requesting: CPU wins.
  - Only loader requesting: loader wins.
  - Both requesting: CPU wins unless starve_cnt == STARVE_LIMIT, in which case the loader wins.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each CPU grant made while ld_req=1.
  - Clears to 0 on any loader grant.
  - Clears to 0 on any arbitration where ld_req=0.
  - Width: clog2(STARVE_LIMIT+1).
- ACCESS (exactly one cycle):
  - mem_writeEn = we_q & rst, gated combinationally, so no write is committed on a reset edge.
  - On the closing edge: a read latches mem_outData into the winner's rdata register; a write leaves rdata unchanged. Go to ACK.
- ACK (one cycle):
  - The winner's ack=1.
  - Requests are ignored in this cycle, because the acked requester may still be holding req.
  - Go to IDLE.
- The requester drops req, or presents a new request, after sampling ack. A req still high in the following IDLE cycle is treated as a new request.
- mem_address and mem_inData hold their last values outside ACCESS. mem_writeEn=0 outside ACCESS.
- Non-winner ack stays 0. Changing addr, we or wdata while waiting before a grant is legal; the value sampled in IDLE is used.

## Timing
- Reset (rst=0 at an edge):
  - state=IDLE, starve_cnt=0.
  - cpu_ack=ld_ack=0, cpu_rdata=ld_rdata=0.
  - mem_address=0, mem_inData=0, busy=0.
  - mem_writeEn=0 immediately (combinational gate).
- Latency: req first seen in IDLE at edge k; ACCESS in cycle k+1; ack=1 in cycle k+2; IDLE again in cycle k+3.
- Throughput: one access every 3 cycles.
- Simultaneous requests: resolved at the IDLE edge only. A request arriving during ACCESS or ACK waits.
- Reset mid-ACCESS or mid-ACK: the transaction is aborted, no ack is issued, the write is suppressed, and the requester must re-request.
- Addresses cover the full 0…2^ADDR_W−1 range; no wrap logic and no error output.

## Test plan
- Reset: rst=0 for 2 cycles with cpu_req=1 and cpu_we=1 -> mem_writeEn=0 throughout, all outputs 0. After release, the CPU access starts in the first IDLE cycle.
- Single loader write then CPU read:
  - ld write addr=1000, data=0x1A -> mem_writeEn=1 for exactly one cycle with mem_address=1000, and ld_ack in the following cycle.
  - CPU read addr=1000 -> cpu_rdata=0x1A with cpu_ack 2 cycles after the grant.
- Contention: cpu_req and ld_req held continuously with STARVE_LIMIT=4 -> grant order CPU,CPU,CPU,CPU,LD,CPU,… repeating; each ack comes 3 cycles apart.
- Back-to-back: the CPU keeps req=1 through the ACK cycle with a new addr=5 -> the second access starts from the next IDLE with no double-ack, giving 3-cycle spacing.
- Reset during ACCESS of a CPU write to addr=20 with data 0xFF: memory[20] is unchanged, no cpu_ack, state returns to IDLE.
- Read data hold: a CPU read returns 0x43, then a CPU write of 0x00 -> cpu_rdata stays 0x43; ld_rdata is unaffected by CPU traffic.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter and access sequencer for the single-port system memory.
// The CPU has fixed priority; a starvation counter guarantees the loader a slot.
// Each access: IDLE (arbitrate) -> ACCESS (one memory cycle) -> ACK (one-cycle ack).
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_inData,
  output logic              mem_writeEn,
  input  logic [DATA_W-1:0] mem_outData,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_grant;
  logic                w_grant_ld;
  logic                r_win_ld;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_starve;
  logic                r_cpu_ack;
  logic                r_ld_ack;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_ld_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and arbitration decision; requests are only looked at in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_ld  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_req || ld_req) begin
          w_grant     = 1'b1;
          w_grant_ld  = ld_req && (!cpu_req || (r_starve == CNT_W'(STARVE_LIMIT)));
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: w_state_nxt = ST_ACK;
      ST_ACK:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Winner latch, starvation counter, read-data capture and ack generation
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_win_ld    <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_starve    <= '0;
      r_cpu_ack   <= 1'b0;
      r_ld_ack    <= 1'b0;
      r_cpu_rdata <= '0;
      r_ld_rdata  <= '0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_ld_ack  <= 1'b0;
      if (w_grant) begin
        r_win_ld <= w_grant_ld;
        r_we     <= w_grant_ld ? ld_we    : cpu_we;
        r_addr   <= w_grant_ld ? ld_addr  : cpu_addr;
        r_wdata  <= w_grant_ld ? ld_wdata : cpu_wdata;
        if (!ld_req || w_grant_ld) begin
          r_starve <= '0;
        end else if (r_starve != CNT_W'(STARVE_LIMIT)) begin
          r_starve <= r_starve + CNT_W'(1);
        end
      end
      if (r_state == ST_ACCESS) begin
        if (r_win_ld) begin
          r_ld_ack <= 1'b1;
          if (!r_we) r_ld_rdata <= mem_outData;
        end else begin
          r_cpu_ack <= 1'b1;
          if (!r_we) r_cpu_rdata <= mem_outData;
        end
      end
    end
  end

  // Write strobe gated by reset so an aborted access never commits
  assign mem_writeEn = (r_state == ST_ACCESS) && r_we && rst;
  assign mem_address = r_addr;
  assign mem_inData  = r_wdata;
  assign busy        = (r_state != ST_IDLE);
  assign cpu_ack     = r_cpu_ack;
  assign ld_ack      = r_ld_ack;
  assign cpu_rdata   = r_cpu_rdata;
  assign ld_rdata    = r_ld_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 8K x 8 memory.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        ld_req, ld_we;
  logic [12:0] ld_addr;
  logic [7:0]  ld_wdata;
  logic        ld_ack;
  logic [7:0]  ld_rdata;
  logic [12:0] mem_address;
  logic [7:0]  mem_inData;
  logic        mem_writeEn;
  logic [7:0]  mem_outData;
  logic        busy;

  logic [7:0]  mem [0:8191];
  int          n_pass;
  int          n_total;

  mem_arbiter #(.ADDR_W(13), .DATA_W(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_address(mem_address), .mem_inData(mem_inData), .mem_writeEn(mem_writeEn),
    .mem_outData(mem_outData), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_writeEn) mem[mem_address] <= mem_inData;
  end
  assign mem_outData = mem[mem_address];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'd7; cpu_wdata = 8'h55;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = 13'd0; ld_wdata = 8'h00;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_total++; if (mem_writeEn !== 1'b0) $display("FAIL rst_we c%0d got %b exp 0", c, mem_writeEn); else n_pass++;
      n_total++; if ({cpu_ack, ld_ack, busy} !== 3'b000) $display("FAIL rst_flags c%0d got %b exp 000", c, {cpu_ack, ld_ack, busy}); else n_pass++;
      n_total++; if ({cpu_rdata, ld_rdata} !== 16'h0) $display("FAIL rst_rdata c%0d got %h exp 0000", c, {cpu_rdata, ld_rdata}); else n_pass++;
      n_total++; if ({mem_address, mem_inData} !== 21'h0) $display("FAIL rst_mem c%0d got %h exp 0", c, {mem_address, mem_inData}); else n_pass++;
    end
    rst = 1'b1;
    tick();
    n_total++; if ({busy, mem_writeEn} !== 2'b11) $display("FAIL rst_first_access got %b exp 11", {busy, mem_writeEn}); else n_pass++;
    n_total++; if (mem_address !== 13'd7) $display("FAIL rst_first_addr got %0d exp 7", mem_address); else n_pass++;
    tick();
    n_total++; if (cpu_ack !== 1'b1) $display("FAIL rst_first_ack got %b exp 1", cpu_ack); else n_pass++;
    cpu_req = 1'b0;
    tick();
    n_total++; if ({cpu_ack, busy} !== 2'b00) $display("FAIL rst_first_idle got %b exp 00", {cpu_ack, busy}); else n_pass++;
    n_total++; if (mem[7] !== 8'h55) $display("FAIL rst_first_mem got %h exp 55", mem[7]); else n_pass++;
  endtask

  task automatic test_ld_write_cpu_read();
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 13'd1000; ld_wdata = 8'h1A;
    tick();
    n_total++; if (mem_writeEn !== 1'b1) $display("FAIL ldw_we got %b exp 1", mem_writeEn); else n_pass++;
    n_total++; if (mem_address !== 13'd1000) $display("FAIL ldw_addr got %0d exp 1000", mem_address); else n_pass++;
    n_total++; if (mem_inData !== 8'h1A) $display("FAIL ldw_data got %h exp 1a", mem_inData); else n_pass++;
    tick();
    n_total++; if (mem_writeEn !== 1'b0) $display("FAIL ldw_we_one_cycle got %b exp 0", mem_writeEn); else n_pass++;
    n_total++; if ({ld_ack, cpu_ack} !== 2'b10) $display("FAIL ldw_ack got %b exp 10", {ld_ack, cpu_ack}); else n_pass++;
    ld_req = 1'b0;
    tick();
    n_total++; if ({ld_ack, busy} !== 2'b00) $display("FAIL ldw_idle got %b exp 00", {ld_ack, busy}); else n_pass++;
    n_total++; if (mem_address !== 13'd1000) $display("FAIL ldw_addr_hold got %0d exp 1000", mem_address); else n_pass++;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'd1000; cpu_wdata = 8'hEE;
    tick();
    n_total++; if ({busy, mem_writeEn, cpu_ack} !== 3'b100) $display("FAIL cpur_access got %b exp 100", {busy, mem_writeEn, cpu_ack}); else n_pass++;
    tick();
    n_total++; if (cpu_ack !== 1'b1) $display("FAIL cpur_ack got %b exp 1", cpu_ack); else n_pass++;
    n_total++; if (cpu_rdata !== 8'h1A) $display("FAIL cpur_rdata got %h exp 1a", cpu_rdata); else n_pass++;
    n_total++; if (ld_rdata !== 8'h00) $display("FAIL cpur_ld_rdata got %h exp 00", ld_rdata); else n_pass++;
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    logic [9:0] exp_ld;
    exp_ld = 10'b10000_10000;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'd1000;
    ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 13'd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_total++; if (mem_address !== (exp_ld[i] ? 13'd7 : 13'd1000)) $display("FAIL cont_addr i%0d got %0d exp %0d", i, mem_address, exp_ld[i] ? 7 : 1000); else n_pass++;
      n_total++; if ({cpu_ack, ld_ack} !== 2'b00) $display("FAIL cont_access_ack i%0d got %b exp 00", i, {cpu_ack, ld_ack}); else n_pass++;
      tick();
      n_total++; if ({cpu_ack, ld_ack} !== {~exp_ld[i], exp_ld[i]}) $display("FAIL cont_grant i%0d got %b exp %b", i, {cpu_ack, ld_ack}, {~exp_ld[i], exp_ld[i]}); else n_pass++;
      if (exp_ld[i]) begin
        n_total++; if (ld_rdata !== 8'h55) $display("FAIL cont_ld_rdata i%0d got %h exp 55", i, ld_rdata); else n_pass++;
      end else begin
        n_total++; if (cpu_rdata !== 8'h1A) $display("FAIL cont_cpu_rdata i%0d got %h exp 1a", i, cpu_rdata); else n_pass++;
      end
      if (i == 9) begin
        cpu_req = 1'b0; ld_req = 1'b0;
      end
      tick();
      n_total++; if ({cpu_ack, ld_ack, busy} !== 3'b000) $display("FAIL cont_idle i%0d got %b exp 000", i, {cpu_ack, ld_ack, busy}); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'd1000;
    tick();
    tick();
    n_total++; if (cpu_ack !== 1'b1) $display("FAIL b2b_ack1 got %b exp 1", cpu_ack); else n_pass++;
    cpu_addr = 13'd5;
    tick();
    n_total++; if ({cpu_ack, busy} !== 2'b00) $display("FAIL b2b_no_double got %b exp 00", {cpu_ack, busy}); else n_pass++;
    tick();
    n_total++; if ({busy, cpu_ack} !== 2'b10) $display("FAIL b2b_access2 got %b exp 10", {busy, cpu_ack}); else n_pass++;
    n_total++; if (mem_address !== 13'd5) $display("FAIL b2b_addr2 got %0d exp 5", mem_address); else n_pass++;
    tick();
    n_total++; if (cpu_ack !== 1'b1) $display("FAIL b2b_ack2 got %b exp 1", cpu_ack); else n_pass++;
    n_total++; if (cpu_rdata !== 8'h43) $display("FAIL b2b_rdata2 got %h exp 43", cpu_rdata); else n_pass++;
    cpu_req = 1'b0;
    tick();
    n_total++; if (cpu_ack !== 1'b0) $display("FAIL b2b_idle got %b exp 0", cpu_ack); else n_pass++;
  endtask

  task automatic test_read_hold();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'd5; cpu_wdata = 8'h00;
    tick();
    n_total++; if (mem_writeEn !== 1'b1) $display("FAIL hold_we got %b exp 1", mem_writeEn); else n_pass++;
    tick();
    n_total++; if (cpu_ack !== 1'b1) $display("FAIL hold_ack got %b exp 1", cpu_ack); else n_pass++;
    n_total++; if (cpu_rdata !== 8'h43) $display("FAIL hold_cpu_rdata got %h exp 43", cpu_rdata); else n_pass++;
    n_total++; if (ld_rdata !== 8'h55) $display("FAIL hold_ld_rdata got %h exp 55", ld_rdata); else n_pass++;
    cpu_req = 1'b0;
    tick();
    n_total++; if (mem[5] !== 8'h00) $display("FAIL hold_mem got %h exp 00", mem[5]); else n_pass++;
    n_total++; if (cpu_rdata !== 8'h43) $display("FAIL hold_cpu_rdata_idle got %h exp 43", cpu_rdata); else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'd20; cpu_wdata = 8'hFF;
    tick();
    n_total++; if (mem_writeEn !== 1'b1) $display("FAIL abort_we_pre got %b exp 1", mem_writeEn); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (mem_writeEn !== 1'b0) $display("FAIL abort_we_gate got %b exp 0", mem_writeEn); else n_pass++;
    tick();
    cpu_req = 1'b0;
    n_total++; if ({busy, cpu_ack} !== 2'b00) $display("FAIL abort_state got %b exp 00", {busy, cpu_ack}); else n_pass++;
    n_total++; if (cpu_rdata !== 8'h00) $display("FAIL abort_rdata got %h exp 00", cpu_rdata); else n_pass++;
    rst = 1'b1;
    tick();
    n_total++; if ({busy, cpu_ack} !== 2'b00) $display("FAIL abort_after got %b exp 00", {busy, cpu_ack}); else n_pass++;
    n_total++; if (mem[20] !== 8'h3C) $display("FAIL abort_mem got %h exp 3c", mem[20]); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    for (int a = 0; a < 8192; a++) mem[a] = 8'h00;
    mem[5]  = 8'h43;
    mem[20] = 8'h3C;
    test_reset();
    test_ld_write_cpu_read();
    test_contention();
    test_back_to_back();
    test_read_hold();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
